// File: rtl/sorting_arbiter.sv
// Round-robin packet arbiter in front of a single sorting engine: grants one whole packet,
// forwards it with one cycle of latency, truncates at 2**AWIDTH words, then waits for the sorter.
`timescale 1ns/1ps
module sorting_arbiter #(
  parameter int unsigned CH_NUM = 4,
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 3,
  localparam int unsigned GW    = $clog2(CH_NUM)
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic [CH_NUM*DWIDTH-1:0] data_i,
  input  logic [CH_NUM-1:0]        sop_i,
  input  logic [CH_NUM-1:0]        eop_i,
  input  logic [CH_NUM-1:0]        val_i,
  output logic [CH_NUM-1:0]        ready_o,
  input  logic                     busy_i,
  output logic [DWIDTH-1:0]        data_o,
  output logic                     sop_o,
  output logic                     eop_o,
  output logic                     val_o,
  output logic [GW-1:0]            grant_o,
  output logic                     trunc_o
);

  localparam int unsigned MAXLEN = 2 ** AWIDTH;
  localparam int unsigned CW     = AWIDTH + 1;

  typedef enum logic [2:0] {StIdle, StXfer, StDrop, StWaitAck, StWaitDone} state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       rr_q, rr_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DWIDTH-1:0]   data_q, data_d;
  logic                sop_q, sop_d;
  logic                eop_q, eop_d;
  logic                val_q, val_d;
  logic                trunc_q, trunc_d;

  logic [CH_NUM-1:0]   req;
  logic [CH_NUM-1:0]   ready;
  logic [CH_NUM-1:0]   grant_oh;
  logic [GW-1:0]       scan_idx;
  logic [GW-1:0]       win_idx;
  logic                win_found;
  logic                beat_last;
  logic [DWIDTH-1:0]   data_sel;

  // Round-robin search starting at the pointer and wrapping at CH_NUM-1.
  always_comb begin
    req       = val_i & sop_i;
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      scan_idx = GW'((32'(rr_q) + i) % CH_NUM);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    grant_oh          = '0;
    grant_oh[grant_q] = 1'b1;
    data_sel          = data_i[32'(grant_q)*DWIDTH +: DWIDTH];
    beat_last         = (cnt_q == CW'(MAXLEN - 1));
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    val_d   = 1'b0;
    trunc_d = 1'b0;
    ready   = '0;
    unique case (state_q)
      StIdle: begin
        // Stray beats are swallowed; the grant cycle itself accepts nothing.
        ready = val_i & ~sop_i;
        if (!busy_i && win_found) begin
          grant_d = win_idx;
          cnt_d   = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        ready = grant_oh;
        if (val_i[grant_q]) begin
          val_d   = 1'b1;
          data_d  = data_sel;
          sop_d   = (cnt_q == '0);
          eop_d   = eop_i[grant_q] | beat_last;
          trunc_d = beat_last & ~eop_i[grant_q];
          cnt_d   = cnt_q + CW'(1);
          if (eop_i[grant_q]) begin
            state_d = StWaitAck;
          end else if (beat_last) begin
            state_d = StDrop;
          end
        end
      end
      StDrop: begin
        ready = grant_oh;
        if (val_i[grant_q] && eop_i[grant_q]) begin
          state_d = StWaitAck;
        end
      end
      StWaitAck: begin
        if (busy_i) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (!busy_i) begin
          state_d = StIdle;
          rr_d    = (grant_q == GW'(CH_NUM - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q <= StIdle;
      rr_q    <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      val_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      val_q   <= val_d;
      trunc_q <= trunc_d;
    end
  end

  // ready_o is combinational, so it is masked directly while reset is held.
  assign ready_o = srst_i ? '0 : ready;
  assign data_o  = data_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;
  assign val_o   = val_q;
  assign grant_o = grant_q;
  assign trunc_o = trunc_q;

endmodule

// File: tb/tb_sorting_arbiter.sv
// Self-checking bench for sorting_arbiter: packet table plus reset, stray-beat and round-robin
// sequences, with an output scoreboard and a simple sorter busy model.
`timescale 1ns/1ps
module tb_sorting_arbiter;
  localparam int CH = 4;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int MAXLEN = 8;

  logic             clk = 1'b0;
  logic             srst;
  logic [CH*DW-1:0] data_i;
  logic [CH-1:0]    sop_i, eop_i, val_i, ready_o;
  logic             busy_i;
  logic [DW-1:0]    data_o;
  logic             sop_o, eop_o, val_o, trunc_o;
  logic [1:0]       grant_o;

  always #5 clk = ~clk;

  sorting_arbiter #(.CH_NUM(CH), .DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk_i(clk), .srst_i(srst), .data_i(data_i), .sop_i(sop_i), .eop_i(eop_i),
    .val_i(val_i), .ready_o(ready_o), .busy_i(busy_i), .data_o(data_o), .sop_o(sop_o),
    .eop_o(eop_o), .val_o(val_o), .grant_o(grant_o), .trunc_o(trunc_o)
  );

  typedef struct {logic [7:0] data; logic sop; logic eop; logic trunc;} beat_t;
  typedef struct {
    int ch; int len; bit gaps; logic [7:0] base; bit use5;
    int exp_grant; int exp_fwd; int exp_trunc;
  } vec_t;

  beat_t      exp_q[$];
  beat_t      mon_e;
  int         grant_log[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         out_beats = 0;
  int         trunc_cnt = 0;
  logic [7:0] pkt5 [5] = '{8'd7, 8'd3, 8'd9, 8'd1, 8'd4};
  vec_t       tbl [6];
  int         exp_order [6] = '{0, 1, 3, 0, 1, 3};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int ch, input logic v, input logic s, input logic e,
                       input logic [7:0] d);
    val_i[ch] = v;
    sop_i[ch] = s;
    eop_i[ch] = e;
    data_i[ch*DW +: DW] = d;
  endtask

  // Output monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (val_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got data 0x%0h expected no beat at %0t", data_o, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_beat", {data_o, sop_o, eop_o, trunc_o},
                {mon_e.data, mon_e.sop, mon_e.eop, mon_e.trunc});
        end
        out_beats++;
        if (trunc_o) trunc_cnt++;
        if (sop_o) begin
          grant_log.push_back(int'(grant_o));
          check("sop_while_busy", busy_i, 1'b0);
        end
      end else if (sop_o || eop_o || trunc_o) begin
        n_cmp++;
        n_fail++;
        $display("FAIL flags_without_val: got sop/eop/trunc %b%b%b expected 000",
                 sop_o, eop_o, trunc_o);
      end
    end
  end

  // Sorter model: busy rises 2 cycles after eop_o and stays up for 8 cycles.
  initial begin
    busy_i = 1'b0;
    forever begin
      @(negedge clk);
      if (val_o && eop_o) begin
        repeat (2) @(posedge clk);
        #1 busy_i = 1'b1;
        repeat (8) @(posedge clk);
        #1 busy_i = 1'b0;
      end
    end
  end

  task automatic send_packet(input int ch, input int len, input bit gaps, input logic [7:0] base,
                             input bit use5, input int stop);
    int i = 0;
    int t = 0;
    logic [7:0] d;
    logic v;
    while (i < stop && t < 300) begin
      d = use5 ? pkt5[i] : base + 8'(i);
      v = !(gaps && i > 0 && (t % 2) == 1);
      drive(ch, v, i == 0, i == len - 1, d);
      @(negedge clk);
      check("other_ready_low", ready_o & ~(4'b0001 << ch), 0);
      if (v && ready_o[ch]) begin
        if (i < MAXLEN)
          exp_q.push_back('{d, i == 0, (i == len - 1) || (i == MAXLEN - 1),
                            (i == MAXLEN - 1) && (i != len - 1)});
        i++;
      end
      @(posedge clk);
      #1;
      t++;
    end
    drive(ch, 1'b0, 1'b0, 1'b0, 8'h00);
    if (i < stop) check("send_timeout", i, stop);
  endtask

  // Holds a sop-less beat on ch: it must be refused until the sorter finishes, then
  // swallowed once the arbiter is back in idle.
  task automatic wait_idle(input int ch);
    int t = 0;
    bit seen = 0;
    bit done = 0;
    drive(ch, 1'b1, 1'b0, 1'b0, 8'hEE);
    while (!done && t < 100) begin
      @(negedge clk);
      if (busy_i) seen = 1;
      if (seen && !busy_i) begin
        check("ready_low_wait_done", ready_o[ch], 1'b0);
        @(negedge clk);
        check("idle_stray_ready", ready_o[ch], 1'b1);
        done = 1;
      end else begin
        check("ready_low_wait", ready_o[ch], 1'b0);
      end
      t++;
    end
    @(posedge clk);
    #1 drive(ch, 1'b0, 1'b0, 1'b0, 8'h00);
    if (!done) check("wait_idle_timeout", done, 1'b1);
  endtask

  initial begin
    int acc;
    int t;
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int t;
    tbl[0] = '{2, 5,  0, 8'h00, 1, 2, 5, 0};
    tbl[1] = '{1, 11, 0, 8'h20, 0, 1, 8, 1};
    tbl[2] = '{0, 1,  0, 8'hAA, 0, 0, 1, 0};
    tbl[3] = '{3, 8,  0, 8'h30, 0, 3, 8, 0};
    tbl[4] = '{0, 9,  0, 8'h40, 0, 0, 8, 1};
    tbl[5] = '{1, 4,  1, 8'h50, 0, 1, 4, 0};

    srst   = 1'b1;
    val_i  = '0;
    sop_i  = '0;
    eop_i  = '0;
    data_i = '0;
    drive(0, 1'b1, 1'b0, 1'b0, 8'h55);
    repeat (2) @(posedge clk);
    #1 check("reset_state", {val_o, sop_o, eop_o, trunc_o, data_o, ready_o, grant_o}, 0);
    #2 srst = 1'b0;

    // Stray beat on ch0 is accepted and never forwarded.
    @(negedge clk);
    check("stray_ready", ready_o, 4'b0001);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check("stray_dropped", out_beats, 0);

    for (int k = 0; k < 6; k++) begin
      out_beats = 0;
      trunc_cnt = 0;
      send_packet(tbl[k].ch, tbl[k].len, tbl[k].gaps, tbl[k].base, tbl[k].use5, tbl[k].len);
      wait_idle(tbl[k].ch);
      check("grant", grant_o, tbl[k].exp_grant);
      check("fwd_beats", out_beats, tbl[k].exp_fwd);
      check("trunc_pulses", trunc_cnt, tbl[k].exp_trunc);
      check("queue_drained", exp_q.size(), 0);
    end

    // Reset in the middle of a 6-beat packet after its third beat.
    send_packet(2, 6, 0, 8'h60, 0, 3);
    @(negedge clk);
    #2 srst = 1'b1;
    #1 check("midpkt_reset_outputs", {val_o, sop_o, eop_o, trunc_o, data_o, ready_o, grant_o}, 0);
    check("midpkt_queue", exp_q.size(), 0);
    drive(3, 1'b1, 1'b1, 1'b0, 8'h70);
    @(posedge clk);
    @(posedge clk);
    #3 srst = 1'b0;
    out_beats = 0;
    send_packet(3, 2, 0, 8'h70, 0, 2);
    wait_idle(3);
    check("post_reset_grant", grant_o, 3);
    check("post_reset_beats", out_beats, 2);

    // Round robin among ch0, ch1, ch3 issuing back-to-back 1-beat packets.
    grant_log.delete();
    for (int k = 0; k < CH; k++)
      if (k != 2) drive(k, 1'b1, 1'b1, 1'b1, 8'h10 + 8'(k));
    acc = 0;
    t = 0;
    while (acc < 6 && t < 500) begin
      @(negedge clk);
      for (int k = 0; k < CH; k++) begin
        if (val_i[k] && ready_o[k]) begin
          exp_q.push_back('{8'h10 + 8'(k), 1'b1, 1'b1, 1'b0});
          acc++;
        end
      end
      @(posedge clk);
      #1;
      t++;
    end
    for (int k = 0; k < CH; k++) drive(k, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (30) @(posedge clk);
    check("rr_count", grant_log.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < grant_log.size()) check("rr_order", grant_log[k], exp_order[k]);
    check("rr_queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule
